vga_update_arbiter: RTL and testbench

VGA_UPDATE_ARBITER -- requirements
Module: vga_update_arbiter

---
 rtl/vga_arb_pkg.sv | 14 +
 rtl/vga_rr_picker.sv | 31 +++
 rtl/vga_update_arbiter.sv | 139 +++++++++++++
 tb/tb_vga_update_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_arb_pkg.sv
// Shared definitions for the VGA character-RAM update arbiter.
package vga_arb_pkg;

  localparam int unsigned ARB_ADDR_W    = 11;
  localparam int unsigned ARB_DATA_W    = 8;
  localparam int unsigned ARB_MAX_BURST = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_HOLDOFF = 2'd2
  } arb_state_e;

endpackage

// File: rtl/vga_rr_picker.sv
// Combinational round-robin select: first set request at or after rr_ptr wins.
module vga_rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] win_c_o,
  output logic [IDX_W-1:0]   win_idx_c_o
);

  logic        found;
  int unsigned pos;

  // Walk the requesters starting at the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    win_c_o     = '0;
    win_idx_c_o = '0;
    found       = 1'b0;
    pos         = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pos = (32'(rr_ptr_i) + i) % NUM_REQ;
      if (!found && req_i[IDX_W'(pos)]) begin
        found                 = 1'b1;
        win_c_o[IDX_W'(pos)]  = 1'b1;
        win_idx_c_o           = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/vga_update_arbiter.sv
// Round-robin arbiter granting bursts of writes to a shared character RAM.
// Define VGA_ARB_BLANK_ONLY_EN to restrict grants to the vertical blank window.
module vga_update_arbiter
  import vga_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ADDR_W    = ARB_ADDR_W,
  parameter int unsigned DATA_W    = ARB_DATA_W,
  parameter int unsigned MAX_BURST = ARB_MAX_BURST
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      vblnk,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        wr_en_i,
  input  logic [NUM_REQ*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] wr_data_i,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_data,
  output logic                      busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    burst_q, burst_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_data_q, ram_data_d;

  logic                win_open_c;
  logic                accept_c;
  logic                last_c;
  logic [IDX_W-1:0]    next_ptr_c;
  logic [NUM_REQ-1:0]  pick_c;
  logic [IDX_W-1:0]    pick_idx_c;

`ifdef VGA_ARB_BLANK_ONLY_EN
  assign win_open_c = vblnk;
`else
  logic unused_vblnk_c;
  assign win_open_c     = 1'b1;
  assign unused_vblnk_c = vblnk;
`endif

  vga_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i       (req),
    .rr_ptr_i    (rr_ptr_q),
    .win_c_o     (pick_c),
    .win_idx_c_o (pick_idx_c)
  );

  assign last_c     = (burst_q == CNT_W'(MAX_BURST - 1));
  assign next_ptr_c = (32'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + IDX_W'(1);

  // Next-state, grant, burst and RAM-write decode.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    burst_d    = burst_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    accept_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((|req) && win_open_c) begin
          state_d = ST_GRANT;
          gnt_d   = pick_c;
          owner_d = pick_idx_c;
        end
      end
      ST_GRANT: begin
        // A strobe in the cycle the window closes is dropped.
        accept_c = win_open_c && gnt_q[owner_q] && wr_en_i[owner_q];
        if (accept_c) begin
          ram_we_d   = 1'b1;
          ram_addr_d = wr_addr_i[32'(owner_q)*ADDR_W +: ADDR_W];
          ram_data_d = wr_data_i[32'(owner_q)*DATA_W +: DATA_W];
          burst_d    = burst_q + CNT_W'(1);
        end
        if (!win_open_c || !req[owner_q] || (accept_c && last_c)) begin
          state_d  = ST_HOLDOFF;
          gnt_d    = '0;
          rr_ptr_d = next_ptr_c;
          burst_d  = '0;
        end
      end
      ST_HOLDOFF: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      burst_q    <= '0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      burst_q    <= burst_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
    end
  end

  assign gnt      = gnt_q;
  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vga_update_arbiter.sv
// Directed bench for vga_update_arbiter with a write scoreboard.
module tb_vga_update_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 11;
  localparam int unsigned DW = 8;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            vblnk = 1'b1;
  logic [N-1:0]    req;
  logic [N-1:0]    wr_en;
  logic [N*AW-1:0] wr_addr;
  logic [N*DW-1:0] wr_data;
  logic [N-1:0]    gnt;
  logic            ram_we;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_data;
  logic            busy;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t sb[$];
  int  tests    = 0;
  int  fails    = 0;
  int  we_count = 0;
  int  base     = 0;

  always #5 clk = ~clk;

  vga_update_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vblnk     (vblnk),
    .req       (req),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .gnt       (gnt),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_slot(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_addr[k*AW +: AW] = a;
    wr_data[k*DW +: DW] = d;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  // Advance one clock; any RAM write seen must match the oldest expected entry.
  task automatic step();
    wr_t e;
    @(posedge clk);
    #1;
    if (ram_we === 1'b1) begin
      we_count++;
      chk("write_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_addr", 64'(ram_addr), 64'(e.addr));
        chk("sb_data", 64'(ram_data), 64'(e.data));
      end
    end
  endtask

  initial begin
    req     = '0;
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;

    // Reset state
    #12;
    chk("rst_gnt", gnt, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();

    // Round-robin from pointer 0, then rotated priority after release
    req = 4'b0011;
    step(); chk("A_gnt0", gnt, 4'b0001); chk("A_busy", busy, 1);
    req = 4'b0010;
    step(); chk("A_holdoff_gnt", gnt, 0); chk("A_holdoff_busy", busy, 1);
    step(); chk("A_idle_busy", busy, 0);
    step(); chk("A_gnt1", gnt, 4'b0010);
    req = '0;
    step(); step();

    // Owner 2 write forwarded, concurrent non-owner strobe ignored
    req = 4'b0101;
    step(); chk("B_gnt2", gnt, 4'b0100);
    wr_en = 4'b0101;
    set_slot(2, 11'h123, 8'h5A);
    set_slot(0, 11'h7FF, 8'hFF);
    push(11'h123, 8'h5A);
    step(); chk("B_we", ram_we, 1); chk("B_addr", ram_addr, 11'h123); chk("B_data", ram_data, 8'h5A);
    wr_en = '0;
    step(); chk("B_we_low", ram_we, 0);
    req = 4'b0001;
    step(); chk("B_holdoff", gnt, 0);
    step();
    step(); chk("B_gnt0", gnt, 4'b0001);

    // Burst limit: 100 strobes, only 64 accepted, then requester 1 granted
    req  = 4'b0011;
    base = we_count;
    for (int k = 0; k < 100; k++) begin
      wr_en = 4'b0001;
      set_slot(0, AW'(k), DW'(k + 7));
      if (k < 64) push(AW'(k), DW'(k + 7));
      step();
      if (k == 63) chk("C_holdoff", gnt, 0);
      if (k == 65) chk("C_next_owner", gnt, 4'b0010);
    end
    chk("C_we_count", 64'(we_count - base), 64'd64);
    wr_en = '0;
    req   = '0;
    step(); step(); step();

    // Window close mid-burst
    req = 4'b1000;
    step(); chk("D_gnt3", gnt, 4'b1000);
    wr_en = 4'b1000;
    set_slot(3, 11'h200, 8'h11);
    push(11'h200, 8'h11);
    step();
    set_slot(3, 11'h201, 8'h22);
    vblnk = 1'b0;
`ifndef VGA_ARB_BLANK_ONLY_EN
    push(11'h201, 8'h22);
`endif
    step();
`ifdef VGA_ARB_BLANK_ONLY_EN
    chk("D_closed_gnt", gnt, 0);
    chk("D_discard_we", ram_we, 0);
`else
    chk("D_open_gnt", gnt, 4'b1000);
    chk("D_continue_we", ram_we, 1);
`endif
    vblnk = 1'b1;
    wr_en = '0;
    req   = '0;
    step(); step(); step();

    // Async reset mid-burst clears pointer and outputs
    req = 4'b0010;
    step(); chk("E_gnt1", gnt, 4'b0010);
    req = '0;
    step(); step();
    req = 4'b0100;
    step(); chk("E_gnt2", gnt, 4'b0100);
    wr_en = 4'b0100;
    set_slot(2, 11'h3AA, 8'hC3);
    push(11'h3AA, 8'hC3);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("E_rst_gnt", gnt, 0);
    chk("E_rst_we", ram_we, 0);
    chk("E_rst_busy", busy, 0);
    req   = '0;
    wr_en = 4'b1111;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(); chk("E_no_write_1", ram_we, 0);
    step(); chk("E_no_write_2", ram_we, 0); chk("E_idle_gnt", gnt, 0);
    req   = 4'b0110;
    wr_en = '0;
    step(); chk("E_rr_reset", gnt, 4'b0010);
    req = '0;
    step(); step(); step();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
